// File: rtl/call_stack_ex_if.sv
// Request/response bundle of the return-address stack: control and push data in, top/count/flags out.
interface call_stack_ex_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk_en;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             clear_err;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output clk_en, push, pop, data_in, clear_err,
        input  data_out, count, empty, full, overflow, underflow
    );

    modport slave (
        input  clk_en, push, pop, data_in, clear_err,
        output data_out, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack_ex.sv
// Return-address stack: push=CALL, pop=RET, push+pop replaces the top entry.
// One-cycle state update, zero read latency; no backpressure -- full/empty/error flags report misuse.
module call_stack_ex #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter bit WRAP  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    call_stack_ex_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] waddr;
    logic             we;
    logic             set_ovf;
    logic             set_udf;
    logic             is_empty;
    logic             is_full;

    assign top_idx  = ptr_q - PTR_ONE;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        we      = 1'b0;
        waddr   = ptr_q;
        set_ovf = 1'b0;
        set_udf = 1'b0;

        if (bus.clk_en) begin
            case ({bus.push, bus.pop})
                2'b11: begin
                    if (is_empty) begin
                        // Nothing to replace: degrade to a plain push but still flag the bad pop.
                        we      = 1'b1;
                        ptr_d   = ptr_q + PTR_ONE;
                        count_d = count_q + CNT_ONE;
                        set_udf = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = top_idx;
                    end
                end
                2'b10: begin
                    if (!is_full) begin
                        we      = 1'b1;
                        ptr_d   = ptr_q + PTR_ONE;
                        count_d = count_q + CNT_ONE;
                    end else begin
                        set_ovf = 1'b1;
                        if (WRAP) begin
                            // Slot at ptr holds the oldest entry once the ring is full.
                            we    = 1'b1;
                            ptr_d = ptr_q + PTR_ONE;
                        end
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        ptr_d   = top_idx;
                        count_d = count_q - CNT_ONE;
                    end else begin
                        set_udf = 1'b1;
                    end
                end
                default: ;
            endcase

            if (bus.clear_err) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            if (set_ovf) ovf_d = 1'b1;
            if (set_udf) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately left out of reset; count gates every read.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_q[waddr] <= bus.data_in;
        end
    end

    assign bus.data_out  = is_empty ? '0 : mem_q[top_idx];
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_call_stack_ex.sv
// Drives one stimulus stream into a saturating and a wrapping DEPTH=4 stack and checks both against a list model.
module tb_call_stack_ex;
    localparam int W = 10;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic push;
    logic pop;
    logic [W-1:0] data_in;
    logic clear_err;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    call_stack_ex_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
    call_stack_ex_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

    assign bus0.clk_en = clk_en;    assign bus1.clk_en = clk_en;
    assign bus0.push = push;        assign bus1.push = push;
    assign bus0.pop = pop;          assign bus1.pop = pop;
    assign bus0.data_in = data_in;  assign bus1.data_in = data_in;
    assign bus0.clear_err = clear_err; assign bus1.clear_err = clear_err;

    call_stack_ex #(.WIDTH(W), .DEPTH(D), .WRAP(1'b0)) dut_sat (.clk(clk), .rst(rst), .bus(bus0));
    call_stack_ex #(.WIDTH(W), .DEPTH(D), .WRAP(1'b1)) dut_wrap (.clk(clk), .rst(rst), .bus(bus1));

    // Model: element 0 is the bottom, element mc-1 the top; a wrapping push drops element 0.
    logic [W-1:0] ms [2][D];
    int mc [2];
    bit mo [2];
    bit mu [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mc[i] = 0; mo[i] = 1'b0; mu[i] = 1'b0;
            end else if (clk_en) begin
                bit so, su;
                so = 1'b0; su = 1'b0;
                if (push && pop) begin
                    if (mc[i] == 0) begin ms[i][0] = data_in; mc[i] = 1; su = 1'b1; end
                    else ms[i][mc[i]-1] = data_in;
                end else if (push) begin
                    if (mc[i] < D) begin ms[i][mc[i]] = data_in; mc[i] = mc[i] + 1; end
                    else begin
                        so = 1'b1;
                        if (i == 1) begin
                            for (int k = 0; k < D - 1; k++) ms[i][k] = ms[i][k+1];
                            ms[i][D-1] = data_in;
                        end
                    end
                end else if (pop) begin
                    if (mc[i] == 0) su = 1'b1;
                    else mc[i] = mc[i] - 1;
                end
                mo[i] = so | (mo[i] & ~clear_err);
                mu[i] = su | (mu[i] & ~clear_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mtop(input int i);
        return (mc[i] > 0) ? 32'(ms[i][mc[i]-1]) : 32'd0;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("sat.data_out", 32'(bus0.data_out), mtop(0));
            chk("sat.count", 32'(bus0.count), 32'(mc[0]));
            chk("sat.empty", 32'(bus0.empty), 32'(mc[0] == 0));
            chk("sat.full", 32'(bus0.full), 32'(mc[0] == D));
            chk("sat.overflow", 32'(bus0.overflow), 32'(mo[0]));
            chk("sat.underflow", 32'(bus0.underflow), 32'(mu[0]));
            chk("wrap.data_out", 32'(bus1.data_out), mtop(1));
            chk("wrap.count", 32'(bus1.count), 32'(mc[1]));
            chk("wrap.empty", 32'(bus1.empty), 32'(mc[1] == 0));
            chk("wrap.full", 32'(bus1.full), 32'(mc[1] == D));
            chk("wrap.overflow", 32'(bus1.overflow), 32'(mo[1]));
            chk("wrap.underflow", 32'(bus1.underflow), 32'(mu[1]));
        end
    end

    // Called at a falling edge; returns at the next falling edge, after the rising edge has acted.
    task automatic cyc(input logic p_i, input logic q_i, input logic [W-1:0] d_i,
                       input logic ce_i = 1'b1, input logic clr_i = 1'b0, input logic rst_i = 1'b0);
        push = p_i; pop = q_i; data_in = d_i; clk_en = ce_i; clear_err = clr_i; rst = rst_i;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; clear_err = 1'b0;
        @(negedge clk);
        do_reset();
        started = 1'b1;

        // Reset state
        cyc(1'b0, 1'b0, '0);
        chk("rst.data_out", 32'(bus0.data_out), 32'h0);
        chk("rst.count", 32'(bus0.count), 32'd0);
        chk("rst.empty", 32'(bus0.empty), 32'd1);
        chk("rst.full", 32'(bus0.full), 32'd0);
        chk("rst.flags", {30'd0, bus0.overflow, bus0.underflow}, 32'd0);

        // Basic push/pop
        cyc(1'b1, 1'b0, 10'h001); cyc(1'b1, 1'b0, 10'h002); cyc(1'b1, 1'b0, 10'h003);
        chk("basic.top3", 32'(bus0.data_out), 32'h003);
        chk("basic.count3", 32'(bus0.count), 32'd3);
        cyc(1'b0, 1'b1, '0); cyc(1'b0, 1'b1, '0);
        chk("basic.top1", 32'(bus0.data_out), 32'h001);
        chk("basic.count1", 32'(bus0.count), 32'd1);
        cyc(1'b0, 1'b1, '0);
        chk("basic.empty", 32'(bus0.empty), 32'd1);
        chk("basic.zero", 32'(bus0.data_out), 32'h0);

        // Saturating overflow; the wrapping stack overwrites its oldest entry instead
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 10'(10'h010 + k));
        chk("sat.full4", 32'(bus0.full), 32'd1);
        cyc(1'b1, 1'b0, 10'h3FF);
        chk("sat.top_after_ovf", 32'(bus0.data_out), 32'h013);
        chk("sat.count_after_ovf", 32'(bus0.count), 32'd4);
        chk("sat.ovf", 32'(bus0.overflow), 32'd1);
        chk("wrap.top_after_ovf", 32'(bus1.data_out), 32'h3FF);
        for (int k = 0; k < 4; k++) begin
            chk("sat.pop_seq", 32'(bus0.data_out), 32'(10'h013 - k));
            cyc(1'b0, 1'b1, '0);
        end
        chk("sat.drained", 32'(bus0.empty), 32'd1);

        // Replace on a full stack never overflows
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 10'(10'h020 + k));
        cyc(1'b1, 1'b1, 10'h2AA);
        chk("repl_full.top", 32'(bus0.data_out), 32'h2AA);
        chk("repl_full.count", 32'(bus0.count), 32'd4);
        chk("repl_full.ovf", 32'(bus0.overflow), 32'd0);

        // Wrapping overflow
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 10'(10'h010 + k));
        chk("wrap.ovf", 32'(bus1.overflow), 32'd1);
        chk("wrap.count4", 32'(bus1.count), 32'd4);
        chk("wrap.top14", 32'(bus1.data_out), 32'h014);
        for (int k = 0; k < 4; k++) begin
            chk("wrap.pop_seq", 32'(bus1.data_out), 32'(10'h014 - k));
            cyc(1'b0, 1'b1, '0);
        end
        chk("wrap.udf_before", 32'(bus1.underflow), 32'd0);
        cyc(1'b0, 1'b1, '0);
        chk("wrap.udf_fifth", 32'(bus1.underflow), 32'd1);

        // Simultaneous push+pop
        do_reset();
        cyc(1'b1, 1'b0, 10'h050);
        cyc(1'b1, 1'b1, 10'h0AA);
        chk("tail.count", 32'(bus0.count), 32'd1);
        chk("tail.top", 32'(bus0.data_out), 32'h0AA);
        chk("tail.flags", {30'd0, bus0.overflow, bus0.underflow}, 32'd0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, 10'h123);
        chk("tail_empty.count", 32'(bus0.count), 32'd1);
        chk("tail_empty.top", 32'(bus0.data_out), 32'h123);
        chk("tail_empty.udf", 32'(bus0.underflow), 32'd1);

        // Clock enable, error clearing, mid-stack reset
        do_reset();
        cyc(1'b1, 1'b0, 10'h055);
        cyc(1'b1, 1'b0, 10'h066, 1'b0);
        chk("ce.count", 32'(bus0.count), 32'd1);
        chk("ce.top", 32'(bus0.data_out), 32'h055);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, '0);
        chk("err.udf_set", 32'(bus0.underflow), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("err.clear_gated", 32'(bus0.underflow), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("err.cleared", 32'(bus0.underflow), 32'd0);
        cyc(1'b0, 1'b1, '0, 1'b1, 1'b1);
        chk("err.set_wins", 32'(bus0.underflow), 32'd1);
        cyc(1'b1, 1'b0, 10'h007);
        cyc(1'b1, 1'b0, 10'h008);
        chk("mid.count2", 32'(bus0.count), 32'd2);
        cyc(1'b1, 1'b1, 10'h3AB, 1'b1, 1'b0, 1'b1);
        chk("mid.count0", 32'(bus0.count), 32'd0);
        chk("mid.empty", 32'(bus0.empty), 32'd1);
        chk("mid.udf", 32'(bus0.underflow), 32'd0);
        cyc(1'b0, 1'b0, '0);

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
